// File: rtl/y86_run_ctrl.sv
// y86_run_ctrl: run/step sequencer for the y86seq core.
// The host issues RUN/STEP/STOP/CLEAR over a valid/ready handshake. The
// controller gates the core clock enable, watches the core Stat, stops on
// HLT or on any fault code, and can enforce a per-run cycle budget.
module y86_run_ctrl #(
  parameter int STAT_W     = 3,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STAT_W-1:0] cpu_stat,
  output logic              cpu_en,
  output logic              cpu_clr,
  output logic [2:0]        run_state,
  output logic [STAT_W-1:0] final_stat,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP    = 3'd2,
    ST_HALTED  = 3'd3,
    ST_FAULT   = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_STEP  = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [STAT_W-1:0] STAT_AOK = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_HLT = STAT_W'(2);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_BUDGET = CNT_W'(MAX_CYCLES);
  localparam logic               BUDGET_ON  = (MAX_CYCLES != 0);

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [STAT_W-1:0]   fstat_r, fstat_nxt_s;
  logic                done_r, done_nxt_s;
  logic                clr_r, clr_nxt_s;
  logic                take_s;
  logic                en_s;

  // The core only advances while running or stepping; STEP blocks new commands.
  assign en_s      = (state_r == ST_RUN) || (state_r == ST_STEP);
  assign cpu_en    = en_s;
  assign cmd_ready = (state_r != ST_STEP);
  assign take_s    = cmd_valid & cmd_ready;

  assign run_state  = state_r;
  assign final_stat = fstat_r;
  assign cycle_cnt  = cnt_r;
  assign done       = done_r;
  assign cpu_clr    = clr_r;

  // Next-state decode: CLEAR wins, then Stat, then budget, then STEP exit / STOP.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    fstat_nxt_s = fstat_r;
    done_nxt_s  = 1'b0;
    clr_nxt_s   = 1'b0;
    cnt_inc_s   = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    if (take_s && (cmd_op == OP_CLEAR)) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = CNT_ZERO;
      fstat_nxt_s = {STAT_W{1'b0}};
      clr_nxt_s   = 1'b1;
    end else if (en_s) begin
      cnt_nxt_s = cnt_inc_s;
      if (cpu_stat != STAT_AOK) begin
        // Anything but AOK terminates; only HLT counts as a clean halt.
        state_nxt_s = (cpu_stat == STAT_HLT) ? ST_HALTED : ST_FAULT;
        fstat_nxt_s = cpu_stat;
        done_nxt_s  = 1'b1;
      end else if ((state_r == ST_RUN) && BUDGET_ON && (cnt_inc_s == CNT_BUDGET)) begin
        state_nxt_s = ST_TIMEOUT;
        fstat_nxt_s = STAT_AOK;
        done_nxt_s  = 1'b1;
      end else if (state_r == ST_STEP) begin
        state_nxt_s = ST_IDLE;
        done_nxt_s  = 1'b1;
      end else if (take_s && (cmd_op == OP_STOP)) begin
        state_nxt_s = ST_IDLE;
      end else begin
        state_nxt_s = state_r;
      end
    end else if (take_s && (state_r == ST_IDLE) && (cmd_op == OP_RUN)) begin
      state_nxt_s = ST_RUN;
    end else if (take_s && (state_r == ST_IDLE) && (cmd_op == OP_STEP)) begin
      state_nxt_s = ST_STEP;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Register state and every registered output; reset returns everything to zero/IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      fstat_r <= {STAT_W{1'b0}};
      done_r  <= 1'b0;
      clr_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      fstat_r <= fstat_nxt_s;
      done_r  <= done_nxt_s;
      clr_r   <= clr_nxt_s;
    end
  end

endmodule

// File: tb/tb_y86_run_ctrl.sv
// Self-checking bench for y86_run_ctrl: three instances (default, budget=5,
// 4-bit counter) share stimulus; each scenario inspects the relevant one.
module tb_y86_run_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [2:0] cpu_stat;

  logic        a_rdy, a_en, a_clr, a_done, b_rdy, b_en, b_clr, b_done, c_rdy, c_en, c_clr, c_done;
  logic [2:0]  a_st, a_fs, b_st, b_fs, c_st, c_fs;
  logic [31:0] a_cnt, b_cnt;
  logic [3:0]  c_cnt;

  int compared   = 0;
  int mismatched = 0;
  int done_a = 0, done_b = 0, done_c = 0, en_a = 0;

  typedef struct {
    int          sel;
    logic [2:0]  st;
    logic [2:0]  fs;
    logic [31:0] cnt;
  } exp_t;
  exp_t sbq[$];

  localparam logic [1:0] RUN = 2'd0, STEP = 2'd1, STOP = 2'd2, CLEAR = 2'd3;

  always #5 clock = ~clock;

  y86_run_ctrl dut_a (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_rdy), .cmd_op(cmd_op),
    .cpu_stat(cpu_stat), .cpu_en(a_en), .cpu_clr(a_clr), .run_state(a_st),
    .final_stat(a_fs), .cycle_cnt(a_cnt), .done(a_done));

  y86_run_ctrl #(.MAX_CYCLES(5)) dut_b (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_rdy), .cmd_op(cmd_op),
    .cpu_stat(cpu_stat), .cpu_en(b_en), .cpu_clr(b_clr), .run_state(b_st),
    .final_stat(b_fs), .cycle_cnt(b_cnt), .done(b_done));

  y86_run_ctrl #(.CNT_W(4)) dut_c (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(c_rdy), .cmd_op(cmd_op),
    .cpu_stat(cpu_stat), .cpu_en(c_en), .cpu_clr(c_clr), .run_state(c_st),
    .final_stat(c_fs), .cycle_cnt(c_cnt), .done(c_done));

  // Count done pulses and enabled cycles, sampled mid-cycle.
  always @(negedge clock) begin
    if (a_done) done_a <= done_a + 1;
    if (b_done) done_b <= done_b + 1;
    if (c_done) done_c <= done_c + 1;
    if (a_en)   en_a   <= en_a + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    cmd_op    = RUN;
    cpu_stat  = 3'd1;
    reset     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic get_out(input int sel, output logic [2:0] st, output logic [2:0] fs,
                         output logic [31:0] cnt, output logic dn, output logic en,
                         output logic rdy, output logic clr);
    if (sel == 0) begin
      st = a_st; fs = a_fs; cnt = a_cnt; dn = a_done; en = a_en; rdy = a_rdy; clr = a_clr;
    end else if (sel == 1) begin
      st = b_st; fs = b_fs; cnt = b_cnt; dn = b_done; en = b_en; rdy = b_rdy; clr = b_clr;
    end else begin
      st = c_st; fs = c_fs; cnt = {28'd0, c_cnt}; dn = c_done; en = c_en; rdy = c_rdy; clr = c_clr;
    end
  endtask

  task automatic wait_done(input int sel, output int waited);
    logic [2:0] st, fs; logic [31:0] cnt; logic dn, en, rdy, clr;
    waited = 0;
    get_out(sel, st, fs, cnt, dn, en, rdy, clr);
    while (dn !== 1'b1 && waited < 20) begin
      tick();
      waited++;
      get_out(sel, st, fs, cnt, dn, en, rdy, clr);
    end
  endtask

  task automatic test_reset_halt();
    logic [2:0] st, fs; logic [31:0] cnt; logic dn, en, rdy, clr; int w, d0; exp_t e;
    do_reset();
    get_out(0, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({st, fs, cnt, dn, en, rdy, clr} !== {3'd0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_state: got st=%0d fs=%0d cnt=%0d done=%b en=%b rdy=%b clr=%b", st, fs, cnt, dn, en, rdy, clr);
    end
    d0 = done_a;
    send(RUN);
    repeat (9) tick();
    cpu_stat = 3'd2;
    sbq.push_back('{0, 3'd3, 3'd2, 32'd10});
    tick();
    cpu_stat = 3'd1;
    wait_done(0, w);
    compared++;
    if (w !== 0) begin mismatched++; $display("FAIL halt_done_latency: got %0d want 0", w); end
    e = sbq.pop_front();
    get_out(e.sel, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({st, fs, cnt} !== {e.st, e.fs, e.cnt}) begin
      mismatched++;
      $display("FAIL halt_result: got st=%0d fs=%0d cnt=%0d want st=%0d fs=%0d cnt=%0d", st, fs, cnt, e.st, e.fs, e.cnt);
    end
    tick();
    get_out(0, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({en, dn, st} !== {1'b0, 1'b0, 3'd3}) begin
      mismatched++; $display("FAIL halt_after: got en=%b done=%b st=%0d want 0 0 3", en, dn, st);
    end
    compared++;
    if (done_a - d0 !== 1) begin mismatched++; $display("FAIL halt_done_count: got %0d want 1", done_a - d0); end
  endtask

  task automatic test_step();
    logic [2:0] st, fs; logic [31:0] cnt; logic dn, en, rdy, clr; int w, d0, e0; exp_t e;
    do_reset();
    d0 = done_a;
    e0 = en_a;
    for (int i = 0; i < 3; i++) begin
      send(STEP);
      get_out(0, st, fs, cnt, dn, en, rdy, clr);
      compared++;
      if ({st, en, rdy} !== {3'd2, 1'b1, 1'b0}) begin
        mismatched++; $display("FAIL step_active: got st=%0d en=%b rdy=%b want 2 1 0", st, en, rdy);
      end
      sbq.push_back('{0, 3'd0, 3'd0, 32'(i + 1)});
      tick();
      wait_done(0, w);
      compared++;
      if (w !== 0) begin mismatched++; $display("FAIL step_done_latency: got %0d want 0", w); end
      e = sbq.pop_front();
      get_out(e.sel, st, fs, cnt, dn, en, rdy, clr);
      compared++;
      if ({st, fs, cnt, en} !== {e.st, e.fs, e.cnt, 1'b0}) begin
        mismatched++;
        $display("FAIL step_result: got st=%0d fs=%0d cnt=%0d en=%b want st=%0d fs=%0d cnt=%0d en=0", st, fs, cnt, en, e.st, e.fs, e.cnt);
      end
    end
    tick();
    compared++;
    if ({done_a - d0, en_a - e0} !== {32'd3, 32'd3}) begin
      mismatched++; $display("FAIL step_counts: got done=%0d en_cycles=%0d want 3 3", done_a - d0, en_a - e0);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] st, fs; logic [31:0] cnt; logic dn, en, rdy, clr; int w; exp_t e;
    do_reset();
    send(RUN);
    repeat (4) tick();
    get_out(1, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({st, cnt} !== {3'd1, 32'd4}) begin
      mismatched++; $display("FAIL budget_before: got st=%0d cnt=%0d want 1 4", st, cnt);
    end
    sbq.push_back('{1, 3'd5, 3'd1, 32'd5});
    tick();
    wait_done(1, w);
    compared++;
    if (w !== 0) begin mismatched++; $display("FAIL budget_done_latency: got %0d want 0", w); end
    e = sbq.pop_front();
    get_out(e.sel, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({st, fs, cnt} !== {e.st, e.fs, e.cnt}) begin
      mismatched++;
      $display("FAIL budget_result: got st=%0d fs=%0d cnt=%0d want st=%0d fs=%0d cnt=%0d", st, fs, cnt, e.st, e.fs, e.cnt);
    end
    send(RUN);
    tick();
    get_out(1, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({st, cnt, en} !== {3'd5, 32'd5, 1'b0}) begin
      mismatched++; $display("FAIL timeout_sticky: got st=%0d cnt=%0d en=%b want 5 5 0", st, cnt, en);
    end
  endtask

  task automatic test_stop_vs_fault_clear();
    logic [2:0] st, fs; logic [31:0] cnt; logic dn, en, rdy, clr; int w; exp_t e;
    do_reset();
    send(RUN);
    repeat (3) tick();
    cpu_stat  = 3'd4;
    cmd_valid = 1'b1;
    cmd_op    = STOP;
    sbq.push_back('{0, 3'd4, 3'd4, 32'd4});
    tick();
    cmd_valid = 1'b0;
    cpu_stat  = 3'd1;
    wait_done(0, w);
    compared++;
    if (w !== 0) begin mismatched++; $display("FAIL ins_done_latency: got %0d want 0", w); end
    e = sbq.pop_front();
    get_out(e.sel, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({st, fs, cnt} !== {e.st, e.fs, e.cnt}) begin
      mismatched++;
      $display("FAIL ins_beats_stop: got st=%0d fs=%0d cnt=%0d want st=%0d fs=%0d cnt=%0d", st, fs, cnt, e.st, e.fs, e.cnt);
    end
    send(CLEAR);
    get_out(0, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({st, fs, cnt, clr} !== {3'd0, 3'd0, 32'd0, 1'b1}) begin
      mismatched++; $display("FAIL clear_result: got st=%0d fs=%0d cnt=%0d clr=%b want 0 0 0 1", st, fs, cnt, clr);
    end
    tick();
    get_out(0, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if (clr !== 1'b0) begin mismatched++; $display("FAIL clear_pulse_width: got clr=%b want 0", clr); end
  endtask

  task automatic test_bad_stat_and_async_reset();
    logic [2:0] st, fs; logic [31:0] cnt; logic dn, en, rdy, clr; int w, d0; exp_t e;
    do_reset();
    send(RUN);
    cpu_stat = 3'd6;
    sbq.push_back('{0, 3'd4, 3'd6, 32'd1});
    tick();
    cpu_stat = 3'd1;
    wait_done(0, w);
    compared++;
    if (w !== 0) begin mismatched++; $display("FAIL undef_done_latency: got %0d want 0", w); end
    e = sbq.pop_front();
    get_out(e.sel, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({st, fs, cnt} !== {e.st, e.fs, e.cnt}) begin
      mismatched++;
      $display("FAIL undef_stat: got st=%0d fs=%0d cnt=%0d want st=%0d fs=%0d cnt=%0d", st, fs, cnt, e.st, e.fs, e.cnt);
    end
    send(CLEAR);
    send(RUN);
    repeat (3) tick();
    get_out(0, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({en, cnt} !== {1'b1, 32'd3}) begin
      mismatched++; $display("FAIL pre_reset_run: got en=%b cnt=%0d want 1 3", en, cnt);
    end
    d0 = done_a;
    #3;
    reset = 1'b0;
    #1;
    get_out(0, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({st, fs, cnt, dn, en, rdy, clr} !== {3'd0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL async_reset: got st=%0d fs=%0d cnt=%0d done=%b en=%b rdy=%b clr=%b", st, fs, cnt, dn, en, rdy, clr);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    compared++;
    if (done_a !== d0) begin mismatched++; $display("FAIL async_reset_no_done: got %0d pulses want 0", done_a - d0); end
  endtask

  task automatic test_saturate_stop();
    logic [2:0] st, fs; logic [31:0] cnt; logic dn, en, rdy, clr; int d0;
    do_reset();
    send(RUN);
    repeat (20) tick();
    get_out(2, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({st, cnt} !== {3'd1, 32'd15}) begin
      mismatched++; $display("FAIL saturate: got st=%0d cnt=%0d want 1 15", st, cnt);
    end
    d0 = done_c;
    send(STOP);
    get_out(2, st, fs, cnt, dn, en, rdy, clr);
    compared++;
    if ({st, fs, cnt, en} !== {3'd0, 3'd0, 32'd15, 1'b0}) begin
      mismatched++; $display("FAIL stop_result: got st=%0d fs=%0d cnt=%0d en=%b want 0 0 15 0", st, fs, cnt, en);
    end
    tick();
    compared++;
    if (done_c !== d0) begin mismatched++; $display("FAIL stop_no_done: got %0d pulses want 0", done_c - d0); end
  endtask

  initial begin
    test_reset_halt();
    test_step();
    test_timeout();
    test_stop_vs_fault_clear();
    test_bad_stat_and_async_reset();
    test_saturate_stop();
    compared++;
    if (sbq.size() !== 0) begin mismatched++; $display("FAIL scoreboard_leftover: got %0d want 0", sbq.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
